// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg
// Shared constants for the wb_uart_lite serial port: register addresses,
// IIR interrupt identification codes, LSR/MCR/LCR bit positions, the 16x
// oversampling constants and the serial frame state type used by TX and RX.
package uart_lite_pkg;

  // Register map (byte addresses)
  localparam logic [2:0] REG_RBR_THR = 3'd0;  // DLL when DLAB=1
  localparam logic [2:0] REG_IER     = 3'd1;  // DLM when DLAB=1
  localparam logic [2:0] REG_IIR_FCR = 3'd2;
  localparam logic [2:0] REG_LCR     = 3'd3;
  localparam logic [2:0] REG_MCR     = 3'd4;
  localparam logic [2:0] REG_LSR     = 3'd5;
  localparam logic [2:0] REG_MSR     = 3'd6;
  localparam logic [2:0] REG_SCR     = 3'd7;

  // IIR[3:0] identification codes, highest priority first
  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  localparam logic [3:0] IIR_NONE = 4'b0001;

  // LSR bit positions
  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  // MCR / LCR bit positions
  localparam int MCR_DTR  = 0;
  localparam int MCR_RTS  = 1;
  localparam int MCR_OUT1 = 2;
  localparam int MCR_OUT2 = 3;
  localparam int MCR_LOOP = 4;
  localparam int LCR_DLAB = 7;

  // 16 baud ticks per bit; the start bit is re-checked on the 8th tick
  localparam int         OVERSAMPLE       = 16;
  localparam logic [3:0] OVERSAMPLE_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] START_CHECK_TICK = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } serial_state_t;

endpackage

// File: rtl/uart_lite_rx.sv
// uart_lite_rx
// 8N1 receiver: input synchroniser, falling-edge start detect with mid-bit
// glitch rejection, 16x sampling FSM, receive buffer and DR/OE/FE flags.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   baud_tick       1-cycle 16x oversample strobe
//   rx_in           raw serial input (already muxed for loopback)
//   rd_rbr, rd_lsr  bus read strobes clearing DR, and OE/FE
//   rbr             received byte
//   dr, oe, fe      data ready, overrun, framing error flags
module uart_lite_rx
  import uart_lite_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic       rd_rbr,
  input  logic       rd_lsr,
  output logic [7:0] rbr,
  output logic       dr,
  output logic       oe,
  output logic       fe
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  logic                   rx_prev_reg;
  serial_state_t          state_reg, state_next;
  logic [3:0]             tick_cnt_reg, tick_cnt_next;
  logic [2:0]             bit_cnt_reg, bit_cnt_next;
  logic [7:0]             shift_reg, shift_next;
  logic [7:0]             rbr_reg, rbr_next;
  logic                   dr_reg, dr_next, oe_reg, oe_next, fe_reg, fe_next;

  assign rx_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= '1;
      rx_prev_reg  <= 1'b1;
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= 4'd0;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      rbr_reg      <= 8'h00;
      dr_reg       <= 1'b0;
      oe_reg       <= 1'b0;
      fe_reg       <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], rx_in};
      rx_prev_reg  <= rx_s;
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rbr_reg      <= rbr_next;
      dr_reg       <= dr_next;
      oe_reg       <= oe_next;
      fe_reg       <= fe_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rbr_next      = rbr_reg;
    dr_next       = dr_reg;
    oe_next       = oe_reg;
    fe_next       = fe_reg;
    // Clears come first so that a flag being set in the same cycle wins.
    if (rd_rbr) dr_next = 1'b0;
    if (rd_lsr) begin
      oe_next = 1'b0;
      fe_next = 1'b0;
    end
    case (state_reg)
      ST_IDLE: begin
        if (rx_prev_reg && !rx_s) begin
          tick_cnt_next = 4'd0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == START_CHECK_TICK) begin
            if (rx_s) begin
              state_next = ST_IDLE;  // line went back high: glitch
            end else begin
              // Realign so later samples land in the middle of each bit.
              tick_cnt_next = 4'd0;
              bit_cnt_next  = 3'd0;
              state_next    = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == OVERSAMPLE_LAST) begin
            shift_next   = {rx_s, shift_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == OVERSAMPLE_LAST) begin
            rbr_next = shift_reg;
            dr_next  = 1'b1;
            if (dr_reg) oe_next = 1'b1;
            if (!rx_s)  fe_next = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rbr = rbr_reg;
  assign dr  = dr_reg;
  assign oe  = oe_reg;
  assign fe  = fe_reg;

endmodule

// File: rtl/wb_uart_lite.sv
// wb_uart_lite
// Wishbone slave UART, 16550-style register map with single-byte holding
// registers and a fixed 8N1 frame. Contains the bus interface, register
// bank, baud generator, transmitter, modem logic and interrupt logic; the
// receiver lives in uart_lite_rx.
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-low reset
//   wb_adr_i/dat_i/we_i/stb_i/cyc_i, wb_dat_o/ack_o   Wishbone slave
//   int_o                level interrupt request
//   stx_o, srx_i         serial transmit / receive
//   rts_o, dtr_o         modem outputs (inverted MCR bits)
//   cts_i, dsr_i, ri_i, dcd_i   modem inputs, active-low
module wb_uart_lite
  import uart_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [7:0]            wb_dat_i,
  output logic [7:0]            wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  int_o,
  output logic                  stx_o,
  input  logic                  srx_i,
  output logic                  rts_o,
  input  logic                  cts_i,
  output logic                  dtr_o,
  input  logic                  dsr_i,
  input  logic                  ri_i,
  input  logic                  dcd_i
);

  logic [2:0]  reg_adr;
  logic        ack_reg, int_reg;
  logic [7:0]  dat_o_reg, rd_data;
  logic [3:0]  ier_reg;
  logic [7:0]  lcr_reg, scr_reg, dll_reg, dlm_reg, thr_reg;
  logic [4:0]  mcr_reg;
  logic        thre_reg, temt_reg, thre_pend_reg;
  logic        bus_acc, wr_acc, rd_acc, dlab, loop_en;
  logic        wr_thr, wr_dll, wr_dlm, wr_ier, rd_rbr, rd_lsr, rd_iir;
  logic [15:0] divisor, baud_cnt_reg;
  logic        baud_tick;
  logic [7:0]  lsr, msr, iir, rbr;
  logic [3:0]  iir_id, modem_s;
  logic        rx_dr, rx_oe, rx_fe;

  assign reg_adr = wb_adr_i[2:0];
  assign dlab    = lcr_reg[LCR_DLAB];
  assign loop_en = mcr_reg[MCR_LOOP];

  // One access per request; ack gaps prevent back-to-back acks.
  assign bus_acc = wb_stb_i & wb_cyc_i & ~ack_reg;
  assign wr_acc  = bus_acc & wb_we_i;
  assign rd_acc  = bus_acc & ~wb_we_i;
  assign wr_thr  = wr_acc & (reg_adr == REG_RBR_THR) & ~dlab;
  assign wr_dll  = wr_acc & (reg_adr == REG_RBR_THR) & dlab;
  assign wr_ier  = wr_acc & (reg_adr == REG_IER) & ~dlab;
  assign wr_dlm  = wr_acc & (reg_adr == REG_IER) & dlab;
  assign rd_rbr  = rd_acc & (reg_adr == REG_RBR_THR) & ~dlab;
  assign rd_lsr  = rd_acc & (reg_adr == REG_LSR);
  assign rd_iir  = rd_acc & (reg_adr == REG_IIR_FCR);

  // ---------------- baud generator ----------------
  assign divisor   = {dlm_reg, dll_reg};
  assign baud_tick = (divisor != 16'd0) && (baud_cnt_reg == divisor - 16'd1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)                        baud_cnt_reg <= 16'd0;
    else if (wr_dll || wr_dlm || baud_tick) baud_cnt_reg <= 16'd0;
    else if (divisor != 16'd0)            baud_cnt_reg <= baud_cnt_reg + 16'd1;
    else                                  baud_cnt_reg <= 16'd0;
  end

  // ---------------- transmitter ----------------
  serial_state_t tx_state_reg, tx_state_next;
  logic [3:0]    tx_tick_reg, tx_tick_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          tx_line_reg, tx_line_next, tx_load, tx_done;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      tx_state_reg <= ST_IDLE;
      tx_tick_reg  <= 4'd0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'h00;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_tick_reg  <= tx_tick_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_tick_next  = tx_tick_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_line_next  = tx_line_reg;
    tx_load       = 1'b0;
    tx_done       = 1'b0;
    case (tx_state_reg)
      ST_IDLE: begin
        tx_line_next = 1'b1;
        if (!thre_reg) begin
          tx_load       = 1'b1;
          tx_shift_next = thr_reg;
          tx_line_next  = 1'b0;
          tx_tick_next  = 4'd0;
          tx_state_next = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          tx_tick_next = tx_tick_reg + 4'd1;
          if (tx_tick_reg == OVERSAMPLE_LAST) begin
            tx_bit_next   = 3'd0;
            tx_line_next  = tx_shift_reg[0];
            tx_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          tx_tick_next = tx_tick_reg + 4'd1;
          if (tx_tick_reg == OVERSAMPLE_LAST) begin
            if (tx_bit_reg == 3'd7) begin
              tx_line_next  = 1'b1;
              tx_state_next = ST_STOP;
            end else begin
              tx_shift_next = {1'b0, tx_shift_reg[7:1]};
              tx_line_next  = tx_shift_reg[1];
              tx_bit_next   = tx_bit_reg + 3'd1;
            end
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          tx_tick_next = tx_tick_reg + 4'd1;
          if (tx_tick_reg == OVERSAMPLE_LAST) begin
            tx_done       = 1'b1;
            tx_state_next = ST_IDLE;
          end
        end
      end
      default: tx_state_next = ST_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  uart_lite_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .baud_tick(baud_tick),
    .rx_in    (loop_en ? tx_line_reg : srx_i),
    .rd_rbr   (rd_rbr),
    .rd_lsr   (rd_lsr),
    .rbr      (rbr),
    .dr       (rx_dr),
    .oe       (rx_oe),
    .fe       (rx_fe)
  );

  // ---------------- modem inputs ----------------
  logic [3:0] modem_raw;
  assign modem_raw = {dcd_i, ri_i, dsr_i, cts_i};

  for (genvar gi = 0; gi < 4; gi++) begin : g_modem_sync
    logic [SYNC_STAGES-1:0] sync_reg;
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) sync_reg <= '1;
      else           sync_reg <= {sync_reg[SYNC_STAGES-2:0], modem_raw[gi]};
    end
    assign modem_s[gi] = sync_reg[SYNC_STAGES-1];
  end

  assign msr = loop_en ? {mcr_reg[MCR_OUT2], mcr_reg[MCR_OUT1],
                          mcr_reg[MCR_DTR], mcr_reg[MCR_RTS], 4'b0000}
                       : {~modem_s, 4'b0000};

  // ---------------- status / interrupt ----------------
  always_comb begin
    lsr           = 8'h00;
    lsr[LSR_DR]   = rx_dr;
    lsr[LSR_OE]   = rx_oe;
    lsr[LSR_FE]   = rx_fe;
    lsr[LSR_THRE] = thre_reg;
    lsr[LSR_TEMT] = temt_reg;
  end

  always_comb begin
    iir_id = IIR_NONE;
    if (ier_reg[2] && (rx_oe || rx_fe))  iir_id = IIR_RLS;
    else if (ier_reg[0] && rx_dr)        iir_id = IIR_RDA;
    else if (ier_reg[1] && thre_pend_reg) iir_id = IIR_THRE;
  end
  assign iir = {4'b1100, iir_id};

  always_comb begin
    rd_data = 8'h00;
    case (reg_adr)
      REG_RBR_THR: rd_data = dlab ? dll_reg : rbr;
      REG_IER:     rd_data = dlab ? dlm_reg : {4'b0000, ier_reg};
      REG_IIR_FCR: rd_data = iir;
      REG_LCR:     rd_data = lcr_reg;
      REG_MCR:     rd_data = {3'b000, mcr_reg};
      REG_LSR:     rd_data = lsr;
      REG_MSR:     rd_data = msr;
      REG_SCR:     rd_data = scr_reg;
      default:     rd_data = 8'h00;
    endcase
  end

  // ---------------- register bank ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_reg       <= 1'b0;
      dat_o_reg     <= 8'h00;
      int_reg       <= 1'b0;
      ier_reg       <= 4'h0;
      lcr_reg       <= 8'h03;
      mcr_reg       <= 5'h00;
      scr_reg       <= 8'h00;
      dll_reg       <= 8'h00;
      dlm_reg       <= 8'h00;
      thr_reg       <= 8'h00;
      thre_reg      <= 1'b1;
      temt_reg      <= 1'b1;
      thre_pend_reg <= 1'b0;
    end else begin
      ack_reg <= bus_acc;
      int_reg <= ~iir_id[0];
      if (rd_acc) dat_o_reg <= rd_data;
      if (wr_acc) begin
        case (reg_adr)
          REG_LCR: lcr_reg <= wb_dat_i;
          REG_MCR: mcr_reg <= wb_dat_i[4:0];
          REG_SCR: scr_reg <= wb_dat_i;
          default: ;
        endcase
      end
      if (wr_ier) ier_reg <= wb_dat_i[3:0];
      if (wr_dll) dll_reg <= wb_dat_i;
      if (wr_dlm) dlm_reg <= wb_dat_i;

      if (tx_load) begin
        thre_reg <= 1'b1;
        temt_reg <= 1'b0;
      end
      if (tx_done && thre_reg) temt_reg <= 1'b1;
      // A THR write landing on the load cycle keeps the new byte pending.
      if (wr_thr) begin
        thr_reg  <= wb_dat_i;
        thre_reg <= 1'b0;
      end

      if (tx_load || (wr_ier && wb_dat_i[1] && !ier_reg[1] && thre_reg))
        thre_pend_reg <= 1'b1;
      if (wr_thr || (rd_iir && iir_id == IIR_THRE))
        thre_pend_reg <= 1'b0;
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_o_reg;
  assign int_o    = int_reg;
  assign stx_o    = loop_en | tx_line_reg;
  assign rts_o    = loop_en | ~mcr_reg[MCR_RTS];
  assign dtr_o    = loop_en | ~mcr_reg[MCR_DTR];

endmodule

// File: tb/tb_wb_uart_lite.sv
// tb_wb_uart_lite
// Directed bench for wb_uart_lite: register reset values, divisor latch,
// bus ack timing, 8N1 transmit waveform, loopback receive with interrupts,
// overrun/framing errors, glitch rejection, THRE interrupt and reset abort.
module tb_wb_uart_lite;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] wb_adr = 3'd0;
  logic [7:0] wb_dat_i = 8'h00;
  logic [7:0] wb_dat_o;
  logic       wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
  logic       wb_ack, int_o, stx_o, rts_o, dtr_o;
  logic       srx = 1'b1, cts = 1'b1, dsr = 1'b1, ri = 1'b1, dcd = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  wb_uart_lite #(
    .ADDR_WIDTH (3),
    .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst_n),
    .wb_adr_i(wb_adr),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_we_i (wb_we),
    .wb_stb_i(wb_stb),
    .wb_cyc_i(wb_cyc),
    .wb_ack_o(wb_ack),
    .int_o   (int_o),
    .stx_o   (stx_o),
    .srx_i   (srx),
    .rts_o   (rts_o),
    .cts_i   (cts),
    .dtr_o   (dtr_o),
    .dsr_i   (dsr),
    .ri_i    (ri),
    .dcd_i   (dcd)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [7:0] dat);
    @(negedge clk);
    wb_adr = adr; wb_dat_i = dat; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(negedge clk);
    chk_vec("wr_ack", wb_ack, 1'b1);
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk_vec("wr_ack_drop", wb_ack, 1'b0);
    $display("wr adr=%0d dat=%02h", adr, dat);
  endtask

  task automatic wb_read_chk(input string tag, input logic [2:0] adr, input logic [7:0] exp);
    logic [7:0] d;
    @(negedge clk);
    wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(negedge clk);
    chk_vec("rd_ack", wb_ack, 1'b1);
    d = wb_dat_o;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    chk_vec(tag, d, exp);
    @(negedge clk);
    chk_vec("rd_ack_drop", wb_ack, 1'b0);
    $display("rd adr=%0d dat=%02h (%s)", adr, d, tag);
  endtask

  task automatic wait_int(input string tag);
    for (int i = 0; i < 400 && int_o !== 1'b1; i++) @(negedge clk);
    chk_vec(tag, int_o, 1'b1);
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] rx_byte;
    logic       stx_seen_low;

    // ---------- reset ----------
    repeat (3) @(negedge clk);
    chk_vec("rst_stx", stx_o, 1'b1);
    chk_vec("rst_int", int_o, 1'b0);
    chk_vec("rst_ack", wb_ack, 1'b0);
    chk_vec("rst_dat_o", wb_dat_o, 8'h00);
    chk_vec("rst_rts", rts_o, 1'b1);
    chk_vec("rst_dtr", dtr_o, 1'b1);
    rst_n = 1'b1;
    wb_read_chk("rst_ier", 3'd1, 8'h00);
    wb_read_chk("rst_iir", 3'd2, 8'hC1);
    wb_read_chk("rst_lcr", 3'd3, 8'h03);
    wb_read_chk("rst_mcr", 3'd4, 8'h00);
    wb_read_chk("rst_lsr", 3'd5, 8'h60);
    wb_read_chk("rst_msr", 3'd6, 8'h00);
    wb_read_chk("rst_scr", 3'd7, 8'h00);

    // ---------- divisor latch / scratch ----------
    wb_write(3'd3, 8'h83);
    wb_write(3'd0, 8'h01);
    wb_write(3'd1, 8'h00);
    wb_read_chk("dll", 3'd0, 8'h01);
    wb_read_chk("dlm", 3'd1, 8'h00);
    wb_read_chk("lcr_dlab", 3'd3, 8'h83);
    wb_write(3'd3, 8'h03);
    wb_write(3'd7, 8'h5A);
    wb_read_chk("scr", 3'd7, 8'h5A);

    // held request: ack must pulse, never stay high two cycles
    @(negedge clk);
    wb_adr = 3'd7; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(negedge clk); chk_vec("held_ack1", wb_ack, 1'b1);
    @(negedge clk); chk_vec("held_gap", wb_ack, 1'b0);
    @(negedge clk); chk_vec("held_ack2", wb_ack, 1'b1);
    wb_stb = 1'b0; wb_cyc = 1'b0;
    @(negedge clk); chk_vec("held_drop", wb_ack, 1'b0);

    // ---------- modem ----------
    wb_write(3'd4, 8'h03);
    chk_vec("rts_on", rts_o, 1'b0);
    chk_vec("dtr_on", dtr_o, 1'b0);
    wb_write(3'd4, 8'h1B);
    chk_vec("loop_rts", rts_o, 1'b1);
    chk_vec("loop_dtr", dtr_o, 1'b1);
    wb_read_chk("loop_msr", 3'd6, 8'hB0);
    wb_write(3'd4, 8'h00);
    cts = 1'b0; dcd = 1'b0;
    repeat (4) @(negedge clk);
    wb_read_chk("msr_cts_dcd", 3'd6, 8'h90);
    cts = 1'b1; dcd = 1'b1;
    repeat (4) @(negedge clk);
    wb_read_chk("msr_idle", 3'd6, 8'h00);

    // ---------- transmit waveform, DL=1 ----------
    frame = {1'b1, 8'hA5, 1'b0};
    wb_write(3'd0, 8'hA5);
    for (int i = 0; i < 50 && stx_o !== 1'b0; i++) @(negedge clk);
    chk_vec("tx_start_seen", stx_o, 1'b0);
    repeat (8) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      chk_vec($sformatf("tx_bit%0d", b), stx_o, frame[b]);
      repeat (16) @(negedge clk);
    end
    wb_read_chk("tx_lsr_done", 3'd5, 8'h60);
    wb_write(3'd0, 8'h00);
    wb_read_chk("tx_lsr_shifting", 3'd5, 8'h20);
    wb_write(3'd0, 8'hFF);
    wb_read_chk("tx_lsr_both_busy", 3'd5, 8'h00);
    repeat (400) @(negedge clk);
    wb_read_chk("tx_lsr_idle", 3'd5, 8'h60);

    // ---------- loopback receive with interrupt ----------
    wb_write(3'd4, 8'h10);
    wb_write(3'd1, 8'h01);
    wb_write(3'd0, 8'h3C);
    stx_seen_low = 1'b0;
    for (int i = 0; i < 400 && int_o !== 1'b1; i++) begin
      @(negedge clk);
      if (stx_o !== 1'b1) stx_seen_low = 1'b1;
    end
    chk_vec("lb_int", int_o, 1'b1);
    chk_vec("lb_stx_quiet", stx_seen_low, 1'b0);
    wb_read_chk("lb_iir_rda", 3'd2, 8'hC4);
    repeat (20) @(negedge clk);
    wb_read_chk("lb_lsr_dr", 3'd5, 8'h61);
    wb_read_chk("lb_rbr", 3'd0, 8'h3C);
    wb_read_chk("lb_lsr_clr", 3'd5, 8'h60);
    chk_vec("lb_int_clr", int_o, 1'b0);
    chk_vec("lb_stx", stx_o, 1'b1);

    // ---------- overrun ----------
    wb_write(3'd1, 8'h00);
    wb_write(3'd0, 8'h11);
    repeat (200) @(negedge clk);
    wb_write(3'd0, 8'h22);
    repeat (200) @(negedge clk);
    wb_read_chk("oe_lsr", 3'd5, 8'h63);
    wb_read_chk("oe_lsr_clr", 3'd5, 8'h61);
    wb_read_chk("oe_rbr", 3'd0, 8'h22);
    wb_read_chk("oe_lsr_empty", 3'd5, 8'h60);

    // ---------- glitch rejection on srx_i ----------
    wb_write(3'd4, 8'h00);
    @(negedge clk); srx = 1'b0;
    repeat (3) @(negedge clk); srx = 1'b1;
    repeat (40) @(negedge clk);
    wb_read_chk("glitch_lsr", 3'd5, 8'h60);

    // ---------- framing error on srx_i ----------
    wb_write(3'd1, 8'h04);
    rx_byte = 8'h55;
    srx = 1'b0;
    repeat (16) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      srx = rx_byte[b];
      repeat (16) @(negedge clk);
    end
    srx = 1'b0;  // bad stop bit
    repeat (16) @(negedge clk);
    srx = 1'b1;
    repeat (10) @(negedge clk);
    chk_vec("fe_int", int_o, 1'b1);
    wb_read_chk("fe_iir_rls", 3'd2, 8'hC6);
    wb_read_chk("fe_lsr", 3'd5, 8'h69);
    wb_read_chk("fe_lsr_clr", 3'd5, 8'h61);
    wb_read_chk("fe_rbr", 3'd0, 8'h55);
    chk_vec("fe_int_clr", int_o, 1'b0);
    wb_read_chk("fe_iir_none", 3'd2, 8'hC1);

    // ---------- THRE interrupt ----------
    wb_write(3'd1, 8'h00);
    wb_write(3'd1, 8'h02);
    chk_vec("thre_int", int_o, 1'b1);
    wb_read_chk("thre_iir", 3'd2, 8'hC2);
    wb_read_chk("thre_iir_clr", 3'd2, 8'hC1);
    chk_vec("thre_int_clr", int_o, 1'b0);
    wb_write(3'd1, 8'h00);

    // ---------- reset mid-frame ----------
    wb_write(3'd0, 8'h00);
    repeat (40) @(negedge clk);
    chk_vec("midframe_stx", stx_o, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_vec("abort_stx", stx_o, 1'b1);
    chk_vec("abort_int", int_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_read_chk("abort_lsr", 3'd5, 8'h60);
    wb_read_chk("abort_lcr", 3'd3, 8'h03);

    // ---------- DL=0 after reset: transmitter stalls ----------
    wb_write(3'd0, 8'hA5);
    repeat (60) @(negedge clk);
    chk_vec("dl0_stx_held", stx_o, 1'b0);
    wb_read_chk("dl0_lsr", 3'd5, 8'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
